// File: rtl/cpu_pkg.sv
// Shared register-file constants for the issue/read stage.
package cpu_pkg;
  localparam int DATA_W = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] XZR = 5'd31;
endpackage

// File: rtl/reg_scoreboard.sv
// Per-register outstanding-write bits: set by an accepted claim, cleared by writeback.
module reg_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              claim_en,
  input  logic [REG_AW-1:0] claim_addr,
  input  logic              stall,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  output logic [NREG-1:0]   pending
);

  logic [NREG-1:0] pending_next;

  // Clear is applied before set so a same-cycle claim leaves the new producer pending.
  always_comb begin
    pending_next = pending;
    if (wr_en)
      pending_next[wr_addr] = 1'b0;
    if (claim_en && !stall && (claim_addr != XZR))
      pending_next[claim_addr] = 1'b1;
    pending_next[XZR] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= pending_next;
  end

endmodule

// File: rtl/reg_read_unit.sv
// Two-port register file with writeback bypass, XZR handling and RAW-hazard stall.
module reg_read_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int NREG   = cpu_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic              rd_use_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  input  logic              rd_use_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              claim_en,
  input  logic [REG_AW-1:0] claim_addr,
  output logic              stall,
  output logic [NREG-1:0]   pending
);

  // Handshake: an issuing instruction is accepted (and its claim recorded) only in a
  // cycle where stall is low; while stall is high it must hold its inputs unchanged.

  logic [DATA_W-1:0] regs [NREG-1];
  logic hit_a, hit_b;

  assign hit_a = wr_en && (wr_addr == rd_addr_a);
  assign hit_b = wr_en && (wr_addr == rd_addr_b);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG-1; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != XZR)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != XZR) rd_data_a = hit_a ? wr_data : regs[rd_addr_a];
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != XZR) rd_data_b = hit_b ? wr_data : regs[rd_addr_b];
  end

  // A writeback landing this cycle satisfies the operand through the bypass.
  assign stall = (rd_use_a && pending[rd_addr_a] && !hit_a) ||
                 (rd_use_b && pending[rd_addr_b] && !hit_b);

  reg_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .claim_en   (claim_en),
    .claim_addr (claim_addr),
    .stall      (stall),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .pending    (pending)
  );

endmodule

// File: tb/tb_reg_read_unit.sv
// Directed and random checks of reg_read_unit against an array-based register model.
module tb_reg_read_unit;
  localparam int W = 64;
  localparam int N = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic [4:0]   rd_addr_a, rd_addr_b, wr_addr, claim_addr;
  logic         rd_use_a, rd_use_b, wr_en, claim_en;
  logic [W-1:0] rd_data_a, rd_data_b, wr_data;
  logic         stall;
  logic [N-1:0] pending;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];

  logic [W-1:0] m_reg  [N];
  bit           m_pend [N];

  reg_read_unit dut (
    .clk(clk), .reset(reset),
    .rd_addr_a(rd_addr_a), .rd_use_a(rd_use_a),
    .rd_addr_b(rd_addr_b), .rd_use_b(rd_use_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .stall(stall), .pending(pending)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model
  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [4:0] a);
    if (a == 5'd31) return '0;
    if (wr_en && wr_addr == a) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic model_stall();
    bit sa, sb;
    sa = rd_use_a && m_pend[rd_addr_a] && !(wr_en && wr_addr == rd_addr_a);
    sb = rd_use_b && m_pend[rd_addr_b] && !(wr_en && wr_addr == rd_addr_b);
    return sa || sb;
  endfunction

  function automatic logic [N-1:0] pend_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_clock(input logic st);
    if (wr_en && wr_addr != 5'd31) m_reg[wr_addr] = wr_data;
    if (wr_en) m_pend[wr_addr] = 1'b0;
    if (claim_en && claim_addr != 5'd31 && !st) m_pend[claim_addr] = 1'b1;
  endtask

  // driver
  task automatic drive(input logic we, input logic [4:0] wa, input logic [W-1:0] wd,
                       input logic ce, input logic [4:0] ca,
                       input logic ua, input logic [4:0] aa,
                       input logic ub, input logic [4:0] ab);
    wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca;
    rd_use_a = ua; rd_addr_a = aa;
    rd_use_b = ub; rd_addr_b = ab;
  endtask

  // one clock: check combinational outputs, clock, update model, check scoreboard
  task automatic cycle();
    logic st;
    #1;
    exp_q.push_back(model_read(rd_addr_a));
    exp_q.push_back(model_read(rd_addr_b));
    check("rd_a", rd_data_a, exp_q.pop_front());
    check("rd_b", rd_data_b, exp_q.pop_front());
    st = model_stall();
    check("stall", {63'd0, stall}, {63'd0, st});
    @(posedge clk);
    model_clock(st);
    #1;
    check("pending", {32'd0, pending}, {32'd0, pend_vec()});
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 5'd31;
    return 5'($urandom_range(0, 9));
  endfunction

  initial begin
    model_reset();
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #12;
    check("reset_rd_a", rd_data_a, '0);
    check("reset_stall", {63'd0, stall}, '0);
    check("reset_pending", {32'd0, pending}, '0);
    #10 reset = 1'b1;
    @(posedge clk); #1;

    // same-cycle bypass then storage
    drive(1, 5'd3, 64'h1234, 0, 0, 0, 5'd3, 0, 5'd0);
    #1 check("x3_bypass", rd_data_a, 64'h1234);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 5'd3, 0, 5'd3);
    #1 check("x3_stored_a", rd_data_a, 64'h1234);
    check("x3_stored_b", rd_data_b, 64'h1234);
    cycle();

    // XZR
    drive(1, 5'd31, 64'hFFFF, 0, 0, 0, 5'd31, 0, 5'd31);
    #1 check("xzr_bypass", rd_data_a, '0);
    cycle();
    drive(0, 0, '0, 1, 5'd31, 1, 5'd31, 1, 5'd31);
    #1 check("xzr_a", rd_data_a, '0);
    check("xzr_b", rd_data_b, '0);
    cycle();
    check("xzr_pend", {32'd0, pending}, '0);
    drive(0, 0, '0, 0, 0, 1, 5'd31, 1, 5'd31);
    #1 check("xzr_stall", {63'd0, stall}, '0);
    cycle();

    // claim X7, hazard, writeback resolves it
    drive(0, 0, '0, 1, 5'd7, 0, 0, 0, 0);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 0, 1, 5'd7);
    #1 check("x7_stall", {63'd0, stall}, 64'd1);
    cycle();
    drive(0, 0, '0, 1, 5'd2, 0, 0, 1, 5'd7);
    #1 check("x7_stall_hold", {63'd0, stall}, 64'd1);
    cycle();
    check("x2_claim_dropped", {63'd0, pending[2]}, '0);
    drive(1, 5'd7, 64'hAB, 0, 0, 0, 0, 1, 5'd7);
    #1 check("x7_released", {63'd0, stall}, '0);
    check("x7_bypass", rd_data_b, 64'hAB);
    cycle();
    check("x7_cleared", {63'd0, pending[7]}, '0);

    // unused operand never stalls
    drive(0, 0, '0, 1, 5'd4, 0, 0, 0, 0);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 5'd4, 0, 0);
    #1 check("x4_unused", {63'd0, stall}, '0);
    cycle();
    drive(0, 0, '0, 0, 0, 1, 5'd4, 0, 0);
    #1 check("x4_used", {63'd0, stall}, 64'd1);
    cycle();

    // claim and write same register
    drive(1, 5'd9, 64'h99, 1, 5'd9, 0, 0, 0, 0);
    cycle();
    check("x9_new_producer", {63'd0, pending[9]}, 64'd1);

    // mid-run asynchronous reset
    drive(1, 5'd5, 64'hDEAD, 0, 0, 0, 5'd5, 0, 0);
    cycle();
    drive(0, 0, '0, 0, 0, 0, 5'd5, 0, 0);
    #1 check("x5_before_reset", rd_data_a, 64'hDEAD);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check("x5_after_reset", rd_data_a, '0);
    check("pending_after_reset", {32'd0, pending}, '0);
    #1 reset = 1'b1;
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 4, rand_addr(), {$urandom, $urandom},
            $urandom_range(0, 9) < 4, rand_addr(),
            1'($urandom_range(0, 1)), rand_addr(),
            1'($urandom_range(0, 1)), rand_addr());
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_read_unit.md
REG_READ_UNIT -- requirements
Module: reg_read_unit

Interface
REQ-001 Parameter DATA_W, default 64, register data width in bits.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is log2(NREG) = 5.
REQ-003 clk  input  1  single clock for all state.
REQ-004 reset  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 rd_addr_a  input  5  read port A register index.
REQ-006 rd_use_a  input  1  port A operand is consumed by the issuing instruction.
REQ-007 rd_addr_b  input  5  read port B register index.
REQ-008 rd_use_b  input  1  port B operand is consumed by the issuing instruction.
REQ-009 rd_data_a  output  DATA_W  port A read data.
REQ-010 rd_data_b  output  DATA_W  port B read data.
REQ-011 wr_en  input  1  writeback strobe.
REQ-012 wr_addr  input  5  writeback register index.
REQ-013 wr_data  input  DATA_W  writeback data.
REQ-014 claim_en  input  1  issuing instruction will write claim_addr later.
REQ-015 claim_addr  input  5  destination register being claimed.
REQ-016 stall  output  1  issuing instruction must hold; operand not yet available.
REQ-017 pending  output  NREG  per-register outstanding-write bits, for debug and verification.

Function
REQ-018 Storage: NREG-1 DATA_W-bit registers; index 31 (XZR) has no storage and always reads 0.
REQ-019 Write: on rising clk with wr_en=1 and wr_addr!=31, reg[wr_addr] <= wr_data; writes to 31 are discarded.
REQ-020 Read is combinational: rd_data_x = 0 if rd_addr_x=31; else wr_data if wr_en=1 and wr_addr=rd_addr_x (same-cycle bypass); else reg[rd_addr_x].
REQ-021 Write latency: visible on read ports in the same cycle via bypass and from storage in every following cycle.
REQ-022 Scoreboard: pending[r] sets on rising clk when claim_en=1, claim_addr=r, r!=31, and stall=0.
REQ-023 pending[r] clears on rising clk when wr_en=1 and wr_addr=r.
REQ-024 A claim and a write to the same register in the same cycle leave pending[r]=1 (new producer wins).
REQ-025 A claim to 31 and a claim while stall=1 are ignored.
REQ-026 pending[31] is constant 0.
REQ-027 stall = (rd_use_a & pending[rd_addr_a] & ~hit_a) | (rd_use_b & pending[rd_addr_b] & ~hit_b), where hit_x = wr_en & (wr_addr = rd_addr_x).
REQ-028 stall is purely combinational and has no internal timer.
REQ-029 Operands with rd_use_x=0 never cause a stall.
REQ-030 Port A and port B are fully independent; equal addresses on both ports return identical data.
REQ-031 A write while stall=1 still updates storage and clears pending.

Reset
REQ-032 While reset=0, all storage registers are 0 and pending is all 0, asynchronously and independent of clk.
REQ-033 A write or claim in the cycle in which reset asserts is lost.
REQ-034 Outputs after reset: rd_data_a = rd_data_b = 0 (absent bypass), stall=0, pending=0.
REQ-035 Normal operation resumes on the first rising clk after reset returns to 1.

Structure
REQ-036 Package cpu_pkg holds DATA_W, NREG, REG_AW=5 and XZR=31 constants; the module imports them.
REQ-037 One sub-module, reg_scoreboard, holds the pending bits and claim/clear logic; the parent holds storage, bypass and stall.
REQ-038 Target implementation size is 120-400 lines of RTL.

Verification
REQ-039 Reset pulse mid-run after writing X5=0xDEAD -> pending=0, and reading X5 returns 0 immediately, before the next clk.
REQ-040 Write X3=0x1234 with rd_addr_a=3 in the same cycle -> rd_data_a=0x1234 that cycle and every later cycle.
REQ-041 Write X31=0xFFFF, then read X31 on both ports -> 0; claim X31 -> pending[31]=0 and stall=0.
REQ-042 Claim X7; next cycle rd_use_b=1 with rd_addr_b=7 -> stall=1. Assert wr_en to X7 with 0xAB -> stall=0 and rd_data_b=0xAB that cycle; pending[7]=0 after the edge.
REQ-043 Claim X9 and write X9 in the same cycle -> pending[9]=1 after the edge.
REQ-044 Claim X2 while stall=1 from X7 -> pending[2] stays 0. Claim X4 with rd_addr_a=4 but rd_use_a=0 -> stall=0.
